// File: rtl/gcd_client.sv
`default_nettype none
// ============================================================================
// Module   : gcd_client
// Purpose  : Valid/ready request/response sequencer for one gcd_small engine,
//            with zero-operand bypass and bounded-wait timeout.
// Revision : 1.0
// ============================================================================
module gcd_client #(
    parameter int W       = 15,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_res,
    output logic         rsp_timeout,
    output logic         eng_start,
    output logic [W-1:0] eng_a,
    output logic [W-1:0] eng_b,
    input  logic [W-1:0] eng_res,
    input  logic         eng_done
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BLANK = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_op_a;
    logic [W-1:0]  r_op_b;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rsp_res;
    logic          r_rsp_timeout;
    logic          r_rsp_valid;
    logic          r_req_ready;
    logic          r_eng_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_cnt         <= '0;
            r_rsp_res     <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_req_ready   <= 1'b1;
            r_eng_start   <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op_a      <= req_a;
                        r_op_b      <= req_b;
                        r_req_ready <= 1'b0;
                        // The engine never terminates with a zero first operand.
                        if (req_a == '0) begin
                            r_rsp_res     <= req_b;
                            r_rsp_timeout <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= S_RESP;
                        end else begin
                            r_eng_start <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_BLANK;
                end
                S_BLANK: begin
                    // eng_done may still be high from the previous operation here.
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        r_rsp_res     <= eng_res;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_cnt == c_LIMIT) begin
                        r_rsp_res     <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_res     = r_rsp_res;
    assign rsp_timeout = r_rsp_timeout;
    assign eng_start   = r_eng_start;
    assign eng_a       = r_op_a;
    assign eng_b       = r_op_b;

endmodule
`default_nettype wire

// File: tb/tb_gcd_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_client
// Purpose  : Scoreboard bench for gcd_client with a behavioural gcd engine.
// Revision : 1.0
// ============================================================================
module tb_gcd_client;

    localparam int W  = 15;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_res;
    logic         rsp_timeout;
    logic         eng_start;
    logic [W-1:0] eng_a;
    logic [W-1:0] eng_b;
    logic [W-1:0] eng_res;
    logic         eng_done;

    int checks = 0;
    int passes = 0;

    logic [W:0] sb[$];
    logic [W:0] mon_e;

    int           mode = 0;   // 0: engine model, 1: never done, 2: scripted done
    logic         force_done = 1'b0;
    logic [W-1:0] force_res = '0;
    bit           rand_rdy = 1'b0;

    gcd_client #(.W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_timeout(rsp_timeout),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_res    (eng_res),
        .eng_done   (eng_done)
    );

    always #5 clk = ~clk;

    // Engine stand-in: done stays high from the last operation until one cycle
    // after the new start, so a stale done is visible in the blanking cycle.
    logic [W-1:0] m_x = '0, m_y = '0, m_res = '0, m_pa = '0, m_pb = '0;
    logic         m_done = 1'b0, m_load = 1'b0;

    always @(posedge clk) begin
        if (eng_start) begin
            m_pa   <= eng_a;
            m_pb   <= eng_b;
            m_load <= 1'b1;
        end else if (m_load) begin
            m_x    <= m_pa;
            m_y    <= m_pb;
            m_done <= 1'b0;
            m_load <= 1'b0;
        end else if (!m_done) begin
            if (m_y == '0) begin
                m_done <= 1'b1;
                m_res  <= m_x;
            end else begin
                m_x <= m_y;
                m_y <= m_x % m_y;
            end
        end
    end

    assign eng_done = (mode == 0) ? m_done : ((mode == 2) ? force_done : 1'b0);
    assign eng_res  = (mode == 2) ? force_res : m_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return W'(a);
    endfunction

    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_res", 32'(rsp_res), 32'(mon_e[W-1:0]));
                check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e[W]));
            end
        end
    end

    // Returns at posedge+1 of the cycle following the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 300) begin
            if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check("req_ready_wait", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        if (a == '0)       sb.push_back({1'b0, b});
        else if (mode == 1) sb.push_back({1'b1, {W{1'b0}}});
        else if (mode == 2) sb.push_back({1'b0, force_res});
        else               sb.push_back({1'b0, ref_gcd(a, b)});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int bad_start, bad_ready, bp_bad, early, n;
        logic [W-1:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_res", 32'(rsp_res), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // (12,18): single start pulse, req_ready low until response handshake
        send(15'd12, 15'd18);
        @(negedge clk);
        check("start_t1", 32'(eng_start), 32'd1);
        check("ready_t1", 32'(req_ready), 32'd0);
        check("eng_a", 32'(eng_a), 32'd12);
        check("eng_b", 32'(eng_b), 32'd18);
        bad_start = 0; bad_ready = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (eng_start) bad_start++;
            if (req_ready) bad_ready++;
        end while (!rsp_valid && n < 100);
        check("rsp_seen_12_18", 32'(rsp_valid), 32'd1);
        check("start_single", 32'(bad_start), 32'd0);
        check("ready_held_low", 32'(bad_ready), 32'd0);
        drain();

        // Engine still shows done=1 with result 6 from the previous operation
        send(15'd21, 15'd14);
        drain();

        send(15'd0, 15'd7);
        @(negedge clk);
        check("zero_a_valid", 32'(rsp_valid), 32'd1);
        check("zero_a_res", 32'(rsp_res), 32'd7);
        check("zero_a_nostart", 32'(eng_start), 32'd0);
        drain();
        send(15'd0, 15'd0);
        @(negedge clk);
        check("zero_zero_valid", 32'(rsp_valid), 32'd1);
        drain();
        send(15'd9, 15'd0);
        drain();

        // Backpressure: 5 cycles without rsp_ready, handshake on the 6th
        rsp_ready = 1'b0;
        send(15'd30000, 15'd18000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        check("bp_valid", 32'(rsp_valid), 32'd1);
        check("bp_res", 32'(rsp_res), 32'd6000);
        bp_bad = 0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_res != 15'd6000 || rsp_timeout || req_ready) bp_bad++;
        end
        check("bp_hold", 32'(bp_bad), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_after", 32'(req_ready), 32'd1);
        check("bp_valid_after", 32'(rsp_valid), 32'd0);

        // Timeout: engine never finishes, rsp_valid exactly at t+19
        mode = 1;
        send(15'd5, 15'd3);
        early = 0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i < 19 && rsp_valid) early++;
            if (i == 19) check("to_valid_t19", 32'(rsp_valid), 32'd1);
        end
        check("to_not_early", 32'(early), 32'd0);
        drain();

        // done arrives in the last WAIT cycle: normal result wins
        mode = 2; force_done = 1'b0; force_res = 15'd77;
        send(15'd5, 15'd3);
        early = 0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i < 19 && rsp_valid) early++;
            if (i == 19) check("late_done_t19", 32'(rsp_valid), 32'd1);
            if (i == 17) begin
                @(posedge clk); #1;
                force_done = 1'b1;
            end
        end
        check("late_not_early", 32'(early), 32'd0);
        drain();
        force_done = 1'b0;
        mode = 0;

        // Asynchronous reset in the middle of WAIT
        mode = 1;
        send(15'd100, 15'd35);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_res", 32'(rsp_res), 32'd0);
        check("arst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("arst_eng_start", 32'(eng_start), 32'd0);
        check("arst_eng_a", 32'(eng_a), 32'd0);
        check("arst_eng_b", 32'(eng_b), 32'd0);
        sb.delete();
        mode = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        send(15'd8, 15'd12);
        drain();

        // Random operands with random response backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            send(ra, rb);
        end
        rand_rdy = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/gcd_client.md
# gcd_client

Request-side sequencer for the `gcd_small` engine. It accepts operand pairs on a valid/ready request channel and drives the engine's `start`/`a`/`b`. It waits for a valid `done`, then returns the result on a valid/ready response channel. It sits between a host or pipeline stage and one `gcd_small` instance, and adds zero-operand handling and a bounded-wait timeout.

## Interface
- `W`, 15: operand/result width; must match the engine.
- `TIMEOUT`, 1024: maximum number of WAIT cycles before the request is abandoned; counter width is clog2(TIMEOUT).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock, shared with the engine
- `reset_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request operands present
- `req_ready`  out  1  client can accept a request
- `req_a`  in  W  operand a
- `req_b`  in  W  operand b
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_res`  out  W  gcd result; 0 on timeout
- `rsp_timeout`  out  1  the response is a timeout
- `eng_start`  out  1  one-cycle start pulse to the engine
- `eng_a`  out  W  engine operand a
- `eng_b`  out  W  engine operand b
- `eng_res`  in  W  engine result
- `eng_done`  in  1  engine done, a level signal

## Operation
- States: IDLE, START, BLANK, WAIT, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`&`req_ready`: latch a and b into `op_a`/`op_b`.
  - If a==0: load `rsp_res`=b and `rsp_timeout`=0, then go to RESP, bypassing the engine. The engine never terminates for x=0.
  - Otherwise go to START.
- START: `eng_start`=1 for exactly this cycle, then go to BLANK.
- BLANK
  - `eng_done` is ignored. It still reflects the engine's pre-load state, and a stale high is expected.
  - Clear the timeout counter, then go to WAIT.
- WAIT
  - If `eng_done`=1: capture `eng_res` into `rsp_res`, set `rsp_timeout`=0, go to RESP.
  - Else if the counter equals TIMEOUT-1: set `rsp_res`=0 and `rsp_timeout`=1, go to RESP.
  - Else increment the counter.
  - If `eng_done` and the counter limit coincide, `eng_done` wins.
- RESP: `rsp_valid`=1. Hold `rsp_res` and `rsp_timeout` stable until `rsp_valid`&`rsp_ready`, then go to IDLE.
- `req_ready` = (state==IDLE). No request is accepted while a response is pending, so at most one operation is in flight.
- `eng_a`/`eng_b` are driven from `op_a`/`op_b` at all times and are stable from START until the next accept.
- A timeout does not reset the engine; the next START reloads it.
- b==0 with a!=0 goes through the engine, which returns a.

## Timing
- Reset (`reset_n` low, asynchronous) gives these values; mid-operation reset abandons the operation with no response.

  | Signal / register | Reset value |
  |---|---|
  | state | IDLE |
  | `req_ready` | 1 |
  | `rsp_valid` | 0 |
  | `rsp_res` | 0 |
  | `rsp_timeout` | 0 |
  | `eng_start` | 0 |
  | `eng_a`, `eng_b` | 0 |
  | counter | 0 |

- Accept at cycle t (a!=0):
  - `eng_start` is high in t+1.
  - BLANK is t+2; WAIT starts at t+3, and `eng_done` is trusted from t+3.
  - If `eng_done` is first seen in WAIT at cycle d, `rsp_valid` is high from d+1.
  - Minimum latency (b==0 or a==b engine cases) is `rsp_valid` at t+4 to t+5.
- Accept at t with a==0: `rsp_valid` is high at t+1.
- Timeout: WAIT lasts exactly TIMEOUT cycles, so `rsp_valid` is high at t+3+TIMEOUT.
- Response accepted at cycle r: `req_ready` is high at r+1, and the earliest next accept is r+1.
- No combinational paths between ports: `req_ready`, `rsp_*` and `eng_*` are functions of state and registers only.

## Test plan
- Directed gcd, using a cycle-accurate gcd_small model as the engine:
  - req (12,18) accepted at t: single `eng_start` pulse at t+1.
  - Response `rsp_res`=6 with `rsp_timeout`=0.
  - `req_ready`=0 from t+1 until the response handshake.
- Zero operands:
  - (0,7): `rsp_res`=7 at t+1 and no `eng_start`.
  - (9,0): `rsp_res`=9 at t+4.
  - (0,0): `rsp_res`=0 at t+1.
- Stale done: the engine holds `eng_done`=1 from a prior operation.
  - New request (21,14): the done high in BLANK is ignored.
  - Result 7 is returned, not the old `eng_res`.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - `rsp_valid`, `rsp_res` and `rsp_timeout` are held stable.
  - `req_ready` stays 0.
  - Handshake on cycle 6, then `req_ready`=1 the next cycle.
- Timeout with TIMEOUT=16 and an engine stub that never asserts done:
  - Accept at t gives `rsp_valid` at t+19 with `rsp_timeout`=1 and `rsp_res`=0.
  - Variant: `eng_done` rises exactly at counter=15, giving a normal result with `rsp_timeout`=0.
- Reset mid-WAIT: drop `reset_n` asynchronously between edges.
  - All outputs take their reset values immediately.
  - After release, a (8,12) request returns 4 normally.
